// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared types and widths for the neuron feeder
package neuron_pkg;

  localparam int ACT_W = 8;
  localparam int ACC_W = 32;
  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    STREAM   = 3'd1,
    WAIT_Q   = 3'd2,
    THRESH   = 3'd3,
    WAIT_OUT = 3'd4
  } state_e;

endpackage

// File: rtl/feeder_buf.sv
// rtl/feeder_buf.sv - register array with one write port and one async read port
module feeder_buf #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int W     = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  localparam logic [AW:0] DEPTH_A = (AW + 1)'(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic         wr_ok;
  logic         rd_ok;

  assign wr_ok = {1'b0, wr_addr} < DEPTH_A;
  assign rd_ok = {1'b0, rd_addr} < DEPTH_A;

  // Contents are deliberately not reset so they survive a sys_rst.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = rd_ok ? mem_q[rd_addr] : '0;

endmodule

// File: rtl/neuron_feeder.sv
// rtl/neuron_feeder.sv - streams buffered vectors and a threshold ramp into the neuron stage
module neuron_feeder
  import neuron_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int AW        = 8,
  parameter int THR_COUNT = 255,
  parameter int TIMEOUT   = 1023
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             act_wr_en,
  input  logic [AW-1:0]    act_wr_addr,
  input  logic [ACT_W-1:0] act_wr_data,
  input  logic             wgt_wr_en,
  input  logic [AW-1:0]    wgt_wr_addr,
  input  logic [ACT_W-1:0] wgt_wr_data,
  input  logic [LEN_W-1:0] cfg_length,
  input  logic [ACC_W-1:0] thr_base,
  input  logic [ACC_W-1:0] thr_step,
  input  logic             start,
  input  logic             quant_ready,
  input  logic             neuron_out_valid,
  output logic [ACT_W-1:0] activ_out,
  output logic [ACT_W-1:0] weight_out,
  output logic             in_valid,
  output logic [LEN_W-1:0] in_length,
  output logic [ACC_W-1:0] threshold_out,
  output logic             threshold_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int KW = $clog2(THR_COUNT + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [KW-1:0]    THR_L   = KW'(THR_COUNT);
  localparam logic [WW-1:0]    TMO_L   = WW'(TIMEOUT);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] step_q, step_d;
  logic [KW-1:0]    cnt_q, cnt_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [ACT_W-1:0] activ_q, activ_d;
  logic [ACT_W-1:0] weight_q, weight_d;
  logic             in_valid_q, in_valid_d;
  logic [LEN_W-1:0] in_length_q, in_length_d;
  logic [ACC_W-1:0] thr_out_q, thr_out_d;
  logic             thr_valid_q, thr_valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             idle;
  logic [AW-1:0]    rd_addr;
  logic [ACT_W-1:0] act_rd, wgt_rd;
  logic [ACT_W-1:0] act_first, wgt_first;
  logic [WW-1:0]    wait_inc;

  assign idle     = (state_q == IDLE);
  assign rd_addr  = (state_q == STREAM) ? idx_q[AW-1:0] : '0;
  assign wait_inc = wait_q + WW'(1);

  feeder_buf #(.DEPTH(DEPTH), .AW(AW), .W(ACT_W)) u_act_buf (
    .clk     (sys_clk),
    .wr_en   (act_wr_en && idle),
    .wr_addr (act_wr_addr),
    .wr_data (act_wr_data),
    .rd_addr (rd_addr),
    .rd_data (act_rd)
  );

  feeder_buf #(.DEPTH(DEPTH), .AW(AW), .W(ACT_W)) u_wgt_buf (
    .clk     (sys_clk),
    .wr_en   (wgt_wr_en && idle),
    .wr_addr (wgt_wr_addr),
    .wr_data (wgt_wr_data),
    .rd_addr (rd_addr),
    .rd_data (wgt_rd)
  );

  // Element 0 is registered on the start edge, so a same-cycle write to address 0 is forwarded.
  assign act_first = (act_wr_en && act_wr_addr == '0) ? act_wr_data : act_rd;
  assign wgt_first = (wgt_wr_en && wgt_wr_addr == '0) ? wgt_wr_data : wgt_rd;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    activ_d     = activ_q;
    weight_d    = weight_q;
    in_valid_d  = in_valid_q;
    in_length_d = in_length_q;
    thr_out_d   = thr_out_q;
    thr_valid_d = thr_valid_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_length != '0 && cfg_length <= DEPTH_L) begin
            in_length_d = cfg_length;
            acc_d       = thr_base;
            step_d      = thr_step;
            activ_d     = act_first;
            weight_d    = wgt_first;
            in_valid_d  = 1'b1;
            idx_d       = LEN_W'(1);
            state_d     = STREAM;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      STREAM: begin
        if (idx_q < in_length_q) begin
          activ_d  = act_rd;
          weight_d = wgt_rd;
          idx_d    = idx_q + LEN_W'(1);
        end else begin
          activ_d    = '0;
          weight_d   = '0;
          in_valid_d = 1'b0;
          wait_d     = '0;
          state_d    = WAIT_Q;
        end
      end

      WAIT_Q: begin
        if (quant_ready) begin
          thr_out_d   = acc_q;
          thr_valid_d = 1'b1;
          acc_d       = acc_q + step_q;
          cnt_d       = KW'(1);
          state_d     = THRESH;
        end else if (wait_inc == TMO_L) begin
          err_d       = 1'b1;
          in_length_d = '0;
          state_d     = IDLE;
        end else begin
          wait_d = wait_inc;
        end
      end

      THRESH: begin
        if (cnt_q < THR_L) begin
          thr_out_d = acc_q;
          acc_d     = acc_q + step_q;
          cnt_d     = cnt_q + KW'(1);
        end else begin
          thr_out_d   = '0;
          thr_valid_d = 1'b0;
          wait_d      = '0;
          if (neuron_out_valid) begin
            done_d      = 1'b1;
            in_length_d = '0;
            state_d     = IDLE;
          end else begin
            state_d = WAIT_OUT;
          end
        end
      end

      WAIT_OUT: begin
        if (neuron_out_valid) begin
          done_d      = 1'b1;
          in_length_d = '0;
          state_d     = IDLE;
        end else if (wait_inc == TMO_L) begin
          err_d       = 1'b1;
          in_length_d = '0;
          state_d     = IDLE;
        end else begin
          wait_d = wait_inc;
        end
      end

      default: begin
        activ_d     = '0;
        weight_d    = '0;
        in_valid_d  = 1'b0;
        in_length_d = '0;
        thr_out_d   = '0;
        thr_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      step_q      <= '0;
      cnt_q       <= '0;
      wait_q      <= '0;
      activ_q     <= '0;
      weight_q    <= '0;
      in_valid_q  <= 1'b0;
      in_length_q <= '0;
      thr_out_q   <= '0;
      thr_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      activ_q     <= activ_d;
      weight_q    <= weight_d;
      in_valid_q  <= in_valid_d;
      in_length_q <= in_length_d;
      thr_out_q   <= thr_out_d;
      thr_valid_q <= thr_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign activ_out       = activ_q;
  assign weight_out      = weight_q;
  assign in_valid        = in_valid_q;
  assign in_length       = in_length_q;
  assign threshold_out   = thr_out_q;
  assign threshold_valid = thr_valid_q;
  assign busy            = !idle;
  assign done            = done_q;
  assign err             = err_q;

endmodule

// File: doc/neuron_feeder.md
Name: neuron_feeder

Overview:
- Sequencer directly upstream of the 8-bit neuron stage.
- Holds one activation vector and one weight vector in local buffers, loaded through write ports.
- On start, streams (activation, weight) pairs as a gapless in_valid burst of exactly in_length cycles. The neuron's accumulator restarts on any bubble, so the burst must have none.
- Waits for the neuron's quant_ready, then drives a contiguous 255-cycle threshold ramp, then waits for the neuron's out_valid and reports done.

Parameters:
- DEPTH, 256, entries in each of the activation and weight buffers.
- AW, 8, buffer address width; DEPTH <= 2**AW.
- THR_COUNT, 255, threshold cycles per neuron output.
- TIMEOUT, 1023, maximum wait cycles in WAIT_Q or WAIT_OUT before abort.

Ports:
- sys_clk, input, 1, clock; all logic on the rising edge.
- sys_rst, input, 1, asynchronous active-high reset.
- act_wr_en, input, 1, activation buffer write strobe.
- act_wr_addr, input, AW, activation write address.
- act_wr_data, input, 8, signed activation.
- wgt_wr_en, input, 1, weight buffer write strobe.
- wgt_wr_addr, input, AW, weight write address.
- wgt_wr_data, input, 8, signed weight.
- cfg_length, input, 16, vector length, sampled on start.
- thr_base, input, 32, signed first threshold, sampled on start.
- thr_step, input, 32, signed threshold increment, sampled on start.
- start, input, 1, one-cycle request; honoured only in IDLE.
- quant_ready, input, 1, from neuron; accumulation finished.
- neuron_out_valid, input, 1, from neuron; quantised output produced.
- activ_out, output, 8, to neuron activ_in.
- weight_out, output, 8, to neuron weight_in.
- in_valid, output, 1, to neuron in_valid.
- in_length, output, 16, to neuron in_length; latched length.
- threshold_out, output, 32, to neuron threshold_in.
- threshold_valid, output, 1, to neuron threshold_valid.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse when the neuron output has been produced.
- err, output, 1, one-cycle pulse on rejected start or timeout.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
  - Buffer arrays are not reset; their contents survive reset.
  - Reset mid-operation drops in_valid and threshold_valid within the reset itself, because the reset is asynchronous.
- Buffer writes:
  - Accepted only in IDLE; writes while busy are silently dropped.
  - Addresses >= DEPTH are dropped.
  - Write and start in the same cycle: the write lands first, and the stream sees the new data.
- IDLE:
  - start with 1 <= cfg_length <= DEPTH: latch length, base and step; idx=0; go to STREAM.
  - Otherwise start pulses err for one cycle and the state stays IDLE.
- STREAM:
  - Buffers are read asynchronously; outputs are registered.
  - start in cycle 0 gives in_valid=1 in cycles 1..L, with activ_out=act[k] and weight_out=wgt[k] in cycle k+1.
  - The burst has no gaps.
  - in_length holds L from cycle 1 until the state returns to IDLE.
  - After the last element: in_valid=0, activ_out=0, weight_out=0; go to WAIT_Q.
- WAIT_Q:
  - The neuron pulses quant_ready in cycle L+2.
  - On quant_ready: go to THRESH with k=0.
- THRESH:
  - threshold_valid=1 for exactly THR_COUNT consecutive cycles.
  - threshold_out = thr_base + k*thr_step, for k = 0..THR_COUNT-1.
  - Computed with a running 32-bit adder; results wrap modulo 2^32.
  - After the last cycle: threshold_valid=0, threshold_out=0; go to WAIT_OUT.
  - A neuron_out_valid seen during the final THRESH cycle is also honoured.
- WAIT_OUT:
  - On neuron_out_valid: pulse done for one cycle and return to IDLE.
- Timeout:
  - A wait counter clears on entry to WAIT_Q and WAIT_OUT.
  - When it reaches TIMEOUT: pulse err, force all outputs to 0, return to IDLE.
- Stray inputs: quant_ready or neuron_out_valid in any other state is ignored.
- start while busy is ignored, with no err.

Decomposition:
- Shared package neuron_pkg holds:
  - the state enum: IDLE, STREAM, WAIT_Q, THRESH, WAIT_OUT;
  - constants ACT_W=8, ACC_W=32, LEN_W=16.
- One natural sub-module, feeder_buf: a simple dual-port register array (DEPTH x 8, write port plus async read port), instantiated twice, once for activations and once for weights.

Test Plan:
- Reset and config: assert sys_rst mid-STREAM -> in_valid and threshold_valid drop immediately; busy=0 after release; buffer contents intact on the next run.
- Basic run: load act[0..3]={1,-2,3,4}, wgt={5,6,-7,8}, L=4; drive neuron-model pulses at the required cycles:
  - in_valid in cycles 1-4 with exact pairs;
  - quant_ready model pulse at cycle 6 -> threshold_valid for 255 cycles;
  - out_valid model pulse -> done pulse; a real neuron yields sum=4 and out=255.
- Ramp wrap: thr_base=32'h7FFFFFF0, thr_step=1 -> threshold_out wraps to 32'h80000000 at k=16.
- Rejected start: cfg_length=0 and cfg_length=DEPTH+1 -> err pulse, state stays IDLE.
- Busy writes: write act[0] during STREAM -> dropped; the next run streams the old value.
- Timeout: withhold quant_ready -> err pulse after TIMEOUT cycles in WAIT_Q; state returns to IDLE; outputs 0.
